mem_result_checker: RTL and testbench

- Synthesizable post-halt result checker for the pipelined CPU's data memory; replaces bench-only sorting checks with a reusable hardware block.
- On a rising edge of the CPU halt, it scans a parametrised window of data-memory words through a dedicated read port.
- It verifies the window against one of four selectable properties and reports pass/fail, with the first failing index.
- Sits beside Data_Mem on a secondary read port; usable in simulation and on silicon/FPGA bring-up.

---
 rtl/mem_check_pkg.sv | 26 ++
 rtl/rd_lat_timer.sv | 33 +++
 rtl/mem_result_checker.sv | 153 +++++++++++++++
 tb/tb_mem_result_checker.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_check_pkg.sv
`default_nettype none
// ============================================================================
// mem_check_pkg : shared types and constants for the memory result checker
// Revision      : 1.0
// ============================================================================
package mem_check_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    MODE_ASC_U  = 2'd0,
    MODE_DESC_U = 2'd1,
    MODE_ASC_S  = 2'd2,
    MODE_FIBO   = 2'd3
  } check_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rd_lat_timer.sv
`default_nettype none
// ============================================================================
// rd_lat_timer : down-counter raising the sample strobe RD_LAT cycles after load
// Revision     : 1.0
// ============================================================================
module rd_lat_timer #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic strobe
);

  localparam int CNT_W = 3;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CNT_W'(RD_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Last count before expiry marks the edge on which read data is valid.
  assign strobe = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_result_checker.sv
`default_nettype none
// ============================================================================
// mem_result_checker : post-halt scan of a data-memory window against a property
// Revision           : 1.0
// ============================================================================
module mem_result_checker
  import mem_check_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int WORD_BYTES = 8,
  parameter int BASE_IDX   = 11,
  parameter int COUNT      = 10,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [1:0]        check_mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  err_idx
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_IDX * WORD_BYTES);

  state_t              r_state;
  check_mode_t         r_mode;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_prev1;
  logic [DATA_W-1:0]   r_prev2;
  logic                r_halt_prev;
  logic                r_armed;

  logic                w_start;
  logic                w_load;
  logic                w_sample;
  logic                w_fail;
  logic                w_last;
  logic [DATA_W-1:0]   w_fib_exp;
  logic [ADDR_W-1:0]   w_addr;

  assign w_start = halt && !r_halt_prev && r_armed &&
                   ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load  = w_start || (r_state == ST_CMP);
  assign w_last  = (r_idx == IDX_W'(COUNT - 1));
  assign w_addr  = (ADDR_W'(BASE_IDX) + ADDR_W'(r_idx)) * ADDR_W'(WORD_BYTES);

  rd_lat_timer #(
    .RD_LAT (RD_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .strobe (w_sample)
  );

  always_comb begin
    w_fib_exp = (r_idx < IDX_W'(2)) ? DATA_W'(1) : (r_prev1 + r_prev2);
    w_fail    = 1'b0;
    case (r_mode)
      MODE_ASC_U:  w_fail = (r_idx != '0) && (rd_data < r_prev1);
      MODE_DESC_U: w_fail = (r_idx != '0) && (rd_data > r_prev1);
      MODE_ASC_S:  w_fail = (r_idx != '0) && ($signed(rd_data) < $signed(r_prev1));
      MODE_FIBO:   w_fail = (rd_data != w_fib_exp);
      default:     w_fail = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_ASC_U;
      r_idx       <= '0;
      r_prev1     <= '0;
      r_prev2     <= '0;
      r_halt_prev <= 1'b0;
      r_armed     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_idx     <= '0;
    end else begin
      r_halt_prev <= halt;
      // A halt already high when reset releases must drop before it can start a check.
      if (!halt) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state <= ST_REQ;
            r_mode  <= check_mode_t'(check_mode);
            r_idx   <= '0;
            rd_en   <= 1'b1;
            rd_addr <= BASE_ADDR;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_idx <= '0;
          end
        end

        ST_REQ, ST_WAIT: begin
          rd_en <= 1'b0;
          if (w_sample) begin
            if (w_fail) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b0;
              err_idx <= r_idx;
            end else if (w_last) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b1;
              err_idx <= '0;
            end else begin
              r_state <= ST_CMP;
              r_idx   <= r_idx + IDX_W'(1);
              r_prev1 <= rd_data;
              r_prev2 <= r_prev1;
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_CMP: begin
          r_state <= ST_REQ;
          rd_en   <= 1'b1;
          rd_addr <= w_addr;
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          rd_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_result_checker.sv
`default_nettype none
// ============================================================================
// tb_mem_result_checker : randomized checks of two checker instances vs a window model
// Revision              : 1.0
// ============================================================================
module tb_mem_result_checker;

  localparam int BASE = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt    [2];
  logic [1:0]  mode    [2];
  logic        rd_en   [2];
  logic [63:0] rd_addr [2];
  logic [63:0] rd_data [2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic [15:0] err_idx [2];

  logic [63:0] mem  [2][64];
  logic [63:0] pend [2];
  int          age  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_result_checker #(
    .DATA_W(64), .ADDR_W(64), .WORD_BYTES(8), .BASE_IDX(BASE), .COUNT(10), .RD_LAT(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .halt(halt[0]), .check_mode(mode[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_idx(err_idx[0])
  );

  mem_result_checker #(
    .DATA_W(64), .ADDR_W(64), .WORD_BYTES(8), .BASE_IDX(BASE), .COUNT(20), .RD_LAT(3)
  ) u_dut1 (
    .clk(clk), .rst(rst), .halt(halt[1]), .check_mode(mode[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_idx(err_idx[1])
  );

  function automatic int lat_of(int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int cnt_of(int u);
    return (u == 0) ? 10 : 20;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: data is valid only in the cycle ending on the sample edge, garbage otherwise.
  initial begin
    age[0] = -1;
    age[1] = -1;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rd_en[u] === 1'b1) begin
          pend[u] = rd_addr[u];
          age[u]  = 0;
        end else if (age[u] >= 0) begin
          age[u]++;
        end
        if (age[u] == lat_of(u) - 1 && (pend[u] >> 3) < 64)
          rd_data[u] = mem[u][int'(pend[u] >> 3)];
        else
          rd_data[u] = {$urandom, $urandom};
      end
    end
  end

  // Reference: index of the first element violating the property, -1 if none.
  function automatic int ref_fail(int u, int m);
    logic [63:0] w, p, e;
    for (int i = 0; i < cnt_of(u); i++) begin
      w = mem[u][BASE + i];
      p = (i > 0) ? mem[u][BASE + i - 1] : 64'd0;
      case (m)
        0: if (i > 0 && w < p) return i;
        1: if (i > 0 && w > p) return i;
        2: if (i > 0 && $signed(w) < $signed(p)) return i;
        default: begin
          e = (i < 2) ? 64'd1 : mem[u][BASE + i - 1] + mem[u][BASE + i - 2];
          if (w != e) return i;
        end
      endcase
    end
    return -1;
  endfunction

  task automatic fill_random(int u, int m, bit corrupt);
    logic [63:0] v, a, b;
    int k;
    case (m)
      0: v = 64'($urandom);
      1: v = 64'hF000_0000_0000_0000 + 64'($urandom);
      2: v = -64'($urandom_range(1, 1000));
      default: begin a = 64'd1; b = 64'd1; v = 64'd1; end
    endcase
    for (int i = 0; i < cnt_of(u); i++) begin
      if (m == 3) begin
        v = (i < 2) ? 64'd1 : a + b;
        if (i >= 2) begin a = b; b = v; end
      end
      mem[u][BASE + i] = v;
      if (m == 0 || m == 2) v = v + 64'($urandom_range(0, 5));
      if (m == 1) v = v - 64'($urandom_range(0, 5));
    end
    if (corrupt) begin
      k = $urandom_range(0, cnt_of(u) - 1);
      mem[u][BASE + k] = mem[u][BASE + k] ^ (64'd1 << $urandom_range(0, 63));
    end
  endtask

  task automatic run(int u, int m, string tag, bit repulse);
    int fi, exp_cyc, exp_pulses, e, done_at, pulses, addr_bad, overlap, hold_bad;
    bit seen, busy0;
    fi         = ref_fail(u, m);
    exp_cyc    = (fi < 0) ? cnt_of(u) * (lat_of(u) + 1) - 1 : fi * (lat_of(u) + 1) + lat_of(u);
    exp_pulses = (fi < 0) ? cnt_of(u) : fi + 1;
    e = 0; done_at = -1; pulses = 0; addr_bad = 0; overlap = 0; hold_bad = 0;
    seen = 1'b0; busy0 = 1'b0;
    @(negedge clk);
    mode[u] = 2'(m);
    halt[u] = 1'b1;
    while (!seen && e < 600) begin
      @(negedge clk);
      if (e == 0) begin
        halt[u] = 1'b0;
        busy0   = busy[u];
      end
      if (repulse && e == 2) halt[u] = 1'b1;
      if (repulse && e == 4) halt[u] = 1'b0;
      if (rd_en[u] === 1'b1) begin
        if (rd_addr[u] !== 64'((BASE + pulses) * 8)) addr_bad++;
        pulses++;
      end
      if (busy[u] && done[u]) overlap++;
      if (done[u] === 1'b1) begin
        seen    = 1'b1;
        done_at = e;
      end
      e++;
    end
    chk($sformatf("%s.timeout", tag), 64'(seen), 64'd1);
    chk($sformatf("%s.busy_at_start", tag), 64'(busy0), 64'd1);
    chk($sformatf("%s.done_edge", tag), 64'(done_at), 64'(exp_cyc));
    chk($sformatf("%s.pass", tag), 64'(pass[u]), 64'(fi < 0));
    chk($sformatf("%s.err_idx", tag), 64'(err_idx[u]), 64'((fi < 0) ? 0 : fi));
    chk($sformatf("%s.pulses", tag), 64'(pulses), 64'(exp_pulses));
    chk($sformatf("%s.addr_errs", tag), 64'(addr_bad), 64'd0);
    chk($sformatf("%s.busy_done_overlap", tag), 64'(overlap), 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (rd_en[u] !== 1'b0 || done[u] !== 1'b1 || busy[u] !== 1'b0) hold_bad++;
    end
    chk($sformatf("%s.hold_after_done", tag), 64'(hold_bad), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, idle_bad;
    for (int u = 0; u < 2; u++) begin
      halt[u] = 1'b0;
      mode[u] = 2'd0;
      for (int i = 0; i < 64; i++) mem[u][i] = 64'd0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d.reset_ctl", u), {busy[u], done[u], pass[u], rd_en[u], err_idx[u]}, 64'd0);
      chk($sformatf("u%0d.reset_addr", u), rd_addr[u], 64'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed runs on the single-cycle-latency instance
    for (int i = 0; i < 10; i++) mem[0][BASE + i] = 64'(i + 1);
    run(0, 0, "asc_pass", 1'b0);
    mem[0][BASE + 3] = 64'd9;
    mem[0][BASE + 4] = 64'd4;
    run(0, 0, "asc_fail", 1'b0);
    for (int i = 0; i < 10; i++) mem[0][BASE + i] = 64'(10 - i);
    run(0, 1, "desc_pass", 1'b0);
    run(0, 0, "desc_in_asc", 1'b0);
    mem[0][BASE + 0] = -64'd5;
    mem[0][BASE + 1] = -64'd1;
    mem[0][BASE + 2] = 64'd0;
    mem[0][BASE + 3] = 64'd3;
    for (int i = 4; i < 10; i++) mem[0][BASE + i] = 64'(i);
    run(0, 2, "signed_pass", 1'b0);
    run(0, 0, "signed_as_unsigned", 1'b0);
    for (int i = 0; i < 10; i++) mem[0][BASE + i] = 64'd7;
    run(0, 0, "equal_pass", 1'b0);

    // Fibonacci on the three-cycle-latency instance, with a halt re-pulse mid-scan
    fill_random(1, 3, 1'b0);
    run(1, 3, "fib_pass", 1'b1);
    mem[1][BASE + 6] = 64'd14;
    run(1, 3, "fib_fail6", 1'b0);

    // Asynchronous reset during the wait phase of element 4
    fill_random(1, 3, 1'b0);
    @(negedge clk);
    mode[1] = 2'd3;
    halt[1] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 5; k++) begin
      @(negedge clk);
      if (rd_en[1] === 1'b1) cnt++;
    end
    chk("rst_mid.reached_elem4", 64'(cnt), 64'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_mid.u%0d_ctl", u), {busy[u], done[u], pass[u], rd_en[u], err_idx[u]}, 64'd0);
      chk($sformatf("rst_mid.u%0d_addr", u), rd_addr[u], 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy[1] !== 1'b0 || rd_en[1] !== 1'b0 || done[1] !== 1'b0) idle_bad++;
    end
    chk("rst_mid.no_restart_while_high", 64'(idle_bad), 64'd0);
    halt[1] = 1'b0;
    run(1, 3, "after_reset", 1'b0);

    // Randomized windows, modes and corruptions on both instances
    for (int t = 0; t < 10; t++) begin
      int u, m;
      u = $urandom_range(0, 1);
      m = $urandom_range(0, 3);
      fill_random(u, m, 1'(($urandom_range(0, 1))));
      run(u, m, $sformatf("rnd%0d_u%0d_m%0d", t, u, m), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
